// File: rtl/rtc_port_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_port_regbank
//  Description : CPU port-mapped register bank for an RTC front end.
//                - Write registers that are driven to the RTC writer.
//                - A snapshot of the RTC read-back that stays consistent
//                  while the CPU reads it, with a one-deep pending buffer.
//                - A request/acknowledge handshake FSM for the RTC writer.
//                - A status register.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_port_regbank #(
   parameter int         DW        = 8,
   parameter int         N_CH      = 9,
   parameter logic [7:0] WR_BASE   = 8'h01,
   parameter logic [7:0] RD_BASE   = 8'h0C,
   parameter logic [7:0] CTRL_ADDR = 8'h0A,
   parameter logic [7:0] STAT_ADDR = 8'h0B
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               write_i,
   input  logic               read_i,
   input  logic [7:0]         port_id_i,
   input  logic [DW-1:0]      out_port_i,
   output logic [DW-1:0]      in_port_o,
   output logic [N_CH*DW-1:0] wr_regs_o,
   input  logic [N_CH*DW-1:0] rd_in_i,
   input  logic               rd_valid_i,
   input  logic               listo_es_i,
   output logic               listo_esc_o,
   output logic               listo_ht_o
);

   // ------------------------------------------------------------------------
   // Address map constants and elaboration-time parameter checks
   // ------------------------------------------------------------------------
   localparam int c_WR_LO   = int'(WR_BASE);
   localparam int c_WR_HI   = c_WR_LO + N_CH - 1;
   localparam int c_RD_LO   = int'(RD_BASE);
   localparam int c_RD_HI   = c_RD_LO + N_CH - 1;
   localparam int c_CTRL    = int'(CTRL_ADDR);
   localparam int c_STAT    = int'(STAT_ADDR);

   localparam bit c_OVERLAP =
      ((c_WR_LO <= c_RD_HI) && (c_RD_LO <= c_WR_HI)) ||
      ((c_CTRL >= c_WR_LO) && (c_CTRL <= c_WR_HI))   ||
      ((c_CTRL >= c_RD_LO) && (c_CTRL <= c_RD_HI))   ||
      ((c_STAT >= c_WR_LO) && (c_STAT <= c_WR_HI))   ||
      ((c_STAT >= c_RD_LO) && (c_STAT <= c_RD_HI))   ||
      (c_CTRL == c_STAT)                             ||
      (c_WR_HI > 255) || (c_RD_HI > 255);

   // Lock only makes sense when the first and last snapshot addresses differ.
   localparam bit         c_LOCK_EN  = (N_CH > 1);
   localparam logic [7:0] c_RD_LAST  = 8'(c_RD_HI);

   if (c_OVERLAP) begin : g_addr_overlap
      $error("rtc_port_regbank: overlapping or out-of-range port address map");
   end
   if ((N_CH < 1) || (N_CH > 16)) begin : g_nch_range
      $error("rtc_port_regbank: N_CH must be in 1..16");
   end
   if (DW < 5) begin : g_dw_range
      $error("rtc_port_regbank: DW must be at least 5 to hold the status word");
   end

   // ------------------------------------------------------------------------
   // Handshake FSM encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_REQ  = 2'd1;
   localparam logic [1:0] c_ACK  = 2'd2;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DW-1:0]      wr_q [N_CH];
   logic [DW-1:0]      wr_d [N_CH];
   logic [N_CH*DW-1:0] snap_q,  snap_d;
   logic [N_CH*DW-1:0] pbuf_q,  pbuf_d;
   logic [DW-1:0]      rdata_q, rdata_d;
   logic               new_q,   new_d;
   logic               pend_q,  pend_d;
   logic               lock_q,  lock_d;
   logic               ht_q,    ht_d;
   logic [1:0]         state_q, state_d;

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   logic [N_CH-1:0] wr_sel;
   logic [N_CH-1:0] rd_sel;
   logic            ctrl_hit;
   logic            stat_hit;
   logic            req_hit;
   logic            lock_set;
   logic            lock_clr;
   logic            lock_eff;
   logic            commit;
   logic [4:0]      status;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign wr_sel[gi]               = (port_id_i == 8'(c_WR_LO + gi));
      assign rd_sel[gi]               = (port_id_i == 8'(c_RD_LO + gi));
      assign wr_regs_o[gi*DW +: DW]   = wr_q[gi];
   end

   assign ctrl_hit = (port_id_i == CTRL_ADDR);
   assign stat_hit = (port_id_i == STAT_ADDR);
   assign req_hit  = write_i && ctrl_hit && out_port_i[0];
   assign lock_set = c_LOCK_EN && read_i && (port_id_i == RD_BASE);
   assign lock_clr = read_i && (port_id_i == c_RD_LAST);

   // Lock as seen by an rd_valid on this edge: a read of the first snapshot
   // byte already protects the snapshot, and a read of the last one already
   // releases it, so a coinciding rd_valid commits directly.
   assign lock_eff = (lock_q | lock_set) & ~lock_clr;

   assign status   = {lock_q, pend_q, (state_q == c_ACK), (state_q == c_REQ), new_q};

   // Write-register next state: only the addressed channel loads.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         wr_d[i] = wr_q[i];
         if (write_i && wr_sel[i]) begin
            wr_d[i] = out_port_i;
         end
      end
   end

   // Snapshot / pending buffer / flags next state.
   always_comb begin
      snap_d = snap_q;
      pbuf_d = pbuf_q;
      pend_d = pend_q;
      commit = 1'b0;
      if (rd_valid_i && !lock_eff) begin
         // Fresh data is always newer than anything pending.
         snap_d = rd_in_i;
         pend_d = 1'b0;
         commit = 1'b1;
      end else if (rd_valid_i) begin
         // Snapshot is being read: park the data, latest wins.
         pbuf_d = rd_in_i;
         pend_d = 1'b1;
      end else if (pend_q && !lock_q && !lock_set) begin
         // Lock released on an earlier edge: flush the parked data.
         snap_d = pbuf_q;
         pend_d = 1'b0;
         commit = 1'b1;
      end
      ht_d   = commit;
      lock_d = lock_eff;
      // A commit wins over a status read clearing NEW.
      if (commit) begin
         new_d = 1'b1;
      end else if (read_i && stat_hit) begin
         new_d = 1'b0;
      end else begin
         new_d = new_q;
      end
   end

   // Read-back mux, registered every cycle from the current port address.
   always_comb begin
      rdata_d = '0;
      if (stat_hit) begin
         rdata_d = DW'(status);
      end
      for (int i = 0; i < N_CH; i++) begin
         if (rd_sel[i]) begin
            rdata_d = snap_q[i*DW +: DW];
         end
         if (wr_sel[i]) begin
            rdata_d = wr_q[i];
         end
      end
   end

   // Datapath and flag registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            wr_q[i] <= '0;
         end
         snap_q  <= '0;
         pbuf_q  <= '0;
         rdata_q <= '0;
         new_q   <= 1'b0;
         pend_q  <= 1'b0;
         lock_q  <= 1'b0;
         ht_q    <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            wr_q[i] <= wr_d[i];
         end
         snap_q  <= snap_d;
         pbuf_q  <= pbuf_d;
         rdata_q <= rdata_d;
         new_q   <= new_d;
         pend_q  <= pend_d;
         lock_q  <= lock_d;
         ht_q    <= ht_d;
      end
   end

   // Handshake FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= c_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Handshake FSM next state; requests outside IDLE are dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:  if (req_hit)     state_d = c_REQ;
         c_REQ:   if (listo_es_i)  state_d = c_ACK;
         c_ACK:   if (!listo_es_i) state_d = c_IDLE;
         default:                  state_d = c_IDLE;
      endcase
   end

   // Handshake FSM outputs: request level is decoded from the state register
   // so it falls together with the asynchronous reset.
   always_comb begin
      listo_esc_o = (state_q == c_REQ);
   end

   assign in_port_o  = rdata_q;
   assign listo_ht_o = ht_q;

endmodule
`default_nettype wire
